// File: rtl/axis_packet_source.sv
// AXI-Stream traffic generator: on start, emits a burst of fixed-length packets
// whose payload counts up from a seed across the whole burst.
module axis_packet_source #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic [DATA_W-1:0] seed,
  input  logic              tready,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_r, state_nxt;
  logic [LEN_W-1:0]   len_r, len_nxt;
  logic [CNT_W-1:0]   num_r, num_nxt;
  logic [LEN_W-1:0]   beat_r, beat_nxt;
  logic [GAP_W-1:0]   gap_r, gap_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               done_nxt;
  logic               valid_nxt;
  logic               last_nxt;
  logic               busy_nxt;

  // Next-state and next-output computation; every output is registered from these.
  always_comb begin
    state_nxt = state_r;
    len_nxt   = len_r;
    num_nxt   = num_r;
    beat_nxt  = beat_r;
    gap_nxt   = gap_r;
    data_nxt  = tdata;
    cnt_nxt   = pkt_count;
    done_nxt  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          len_nxt   = pkt_len;
          num_nxt   = num_pkts;
          beat_nxt  = {LEN_W{1'b0}};
          cnt_nxt   = {CNT_W{1'b0}};
          data_nxt  = seed;
          state_nxt = ST_SEND;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        // tvalid is always high in SEND, so tready alone marks a handshake
        if (tready) begin
          data_nxt = tdata + DATA_W'(1);
          if (beat_r == len_r) begin
            beat_nxt = {LEN_W{1'b0}};
            cnt_nxt  = pkt_count + CNT_W'(1);
            if (pkt_count == num_r) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_nxt = ST_GAP;
              gap_nxt   = {GAP_W{1'b0}};
            end else begin
              state_nxt = ST_SEND;
            end
          end else begin
            beat_nxt = beat_r + LEN_W'(1);
          end
        end else begin
          state_nxt = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_nxt = ST_SEND;
        end else begin
          gap_nxt = gap_r + GAP_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    valid_nxt = (state_nxt == ST_SEND);
    busy_nxt  = (state_nxt != ST_IDLE);
    last_nxt  = (state_nxt == ST_SEND) && (beat_nxt == len_nxt);
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r   <= ST_IDLE;
      len_r     <= {LEN_W{1'b0}};
      num_r     <= {CNT_W{1'b0}};
      beat_r    <= {LEN_W{1'b0}};
      gap_r     <= {GAP_W{1'b0}};
      tvalid    <= 1'b0;
      tdata     <= {DATA_W{1'b0}};
      tlast     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt;
      len_r     <= len_nxt;
      num_r     <= num_nxt;
      beat_r    <= beat_nxt;
      gap_r     <= gap_nxt;
      tvalid    <= valid_nxt;
      tdata     <= data_nxt;
      tlast     <= last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pkt_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_axis_packet_source.sv
// Randomized bench for axis_packet_source: two instances (gapped, and gapless
// with a 2-bit packet counter) checked against a queue-based beat model.
module tb_axis_packet_source;

  logic       aclk;
  logic       areset;
  logic       start;
  logic       sel;
  logic [7:0] pkt_len;
  logic [3:0] num_pkts;
  logic [7:0] seed;
  logic       tready;

  logic       a_tvalid, a_tlast, a_busy, a_done;
  logic [7:0] a_tdata;
  logic [3:0] a_cnt;
  logic       b_tvalid, b_tlast, b_busy, b_done;
  logic [7:0] b_tdata;
  logic [1:0] b_cnt;

  logic       start_a, start_b;
  logic       tvalid, tlast, busy, done;
  logic [7:0] tdata;
  logic [3:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  assign start_a   = start & ~sel;
  assign start_b   = start & sel;
  assign tvalid    = sel ? b_tvalid : a_tvalid;
  assign tlast     = sel ? b_tlast  : a_tlast;
  assign busy      = sel ? b_busy   : a_busy;
  assign done      = sel ? b_done   : a_done;
  assign tdata     = sel ? b_tdata  : a_tdata;
  assign pkt_count = sel ? {2'b00, b_cnt} : a_cnt;

  axis_packet_source #(.DATA_W(8), .LEN_W(8), .CNT_W(4), .GAP_CYCLES(2)) dut_a (
    .aclk(aclk), .areset(areset), .start(start_a), .pkt_len(pkt_len),
    .num_pkts(num_pkts), .seed(seed), .tready(tready), .tvalid(a_tvalid),
    .tdata(a_tdata), .tlast(a_tlast), .busy(a_busy), .done(a_done), .pkt_count(a_cnt)
  );

  axis_packet_source #(.DATA_W(8), .LEN_W(8), .CNT_W(2), .GAP_CYCLES(0)) dut_b (
    .aclk(aclk), .areset(areset), .start(start_b), .pkt_len(pkt_len),
    .num_pkts(num_pkts[1:0]), .seed(seed), .tready(tready), .tvalid(b_tvalid),
    .tdata(b_tdata), .tlast(b_tlast), .busy(b_busy), .done(b_done), .pkt_count(b_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts a burst (call at #1 after a rising edge) and checks it to completion,
  // leaving the bench at #1 after the edge that produced done.
  task automatic run_burst(input logic [7:0] sd, input logic [7:0] ln, input logic [3:0] np,
                           input int pct, input int gap, input int cmask, input bit perturb);
    int  q_data[$];
    bit  q_last[$];
    int  q_gap[$];
    int  idx;
    int  cyc;
    int  idle;
    bit  stall;
    logic [7:0] prev_data;
    logic       prev_last;
    idx = 0;
    for (int p = 0; p <= int'(np); p++) begin
      for (int b = 0; b <= int'(ln); b++) begin
        q_data.push_back((int'(sd) + idx) % 256);
        q_last.push_back(b == int'(ln));
        q_gap.push_back((b == 0 && p > 0) ? gap : 0);
        idx++;
      end
    end
    seed     = sd;
    pkt_len  = ln;
    num_pkts = np;
    tready   = 1'b0;
    start    = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_tvalid", 32'(tvalid), 32'd1);
    check("start_tdata", 32'(tdata), 32'(sd));
    check("start_done_low", 32'(done), 32'd0);
    check("start_cnt", 32'(pkt_count), 32'd0);
    cyc       = 0;
    idle      = 0;
    stall     = 1'b0;
    prev_data = 8'h00;
    prev_last = 1'b0;
    while (q_data.size() > 0 && cyc < 20000) begin
      tready = ($urandom_range(99) < pct);
      if (perturb && $urandom_range(9) == 0) begin
        start    = 1'b1;
        pkt_len  = 8'($urandom);
        seed     = 8'($urandom);
        num_pkts = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (tvalid) begin
        if (stall) begin
          check("stall_tdata", 32'(tdata), 32'(prev_data));
          check("stall_tlast", 32'(tlast), 32'(prev_last));
        end else begin
          check("idle_gap", 32'(idle), 32'(q_gap[0]));
        end
        check("tdata", 32'(tdata), 32'(q_data[0]));
        check("tlast", 32'(tlast), 32'(q_last[0]));
        prev_data = tdata;
        prev_last = tlast;
        if (tready) begin
          void'(q_data.pop_front());
          void'(q_last.pop_front());
          void'(q_gap.pop_front());
        end
        stall = !tready;
        idle  = 0;
      end else begin
        if (stall) check("valid_drop", 32'(tvalid), 32'd1);
        check("gap_busy", 32'(busy), 32'd1);
        stall = 1'b0;
        idle++;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    start = 1'b0;
    check("burst_complete", 32'(q_data.size()), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_tvalid", 32'(tvalid), 32'd0);
    check("end_tlast", 32'(tlast), 32'd0);
    check("end_cnt", 32'(pkt_count), 32'((int'(np) + 1) & cmask));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
      check("idle_tvalid", 32'(tvalid), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    areset   = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    pkt_len  = 8'h00;
    num_pkts = 4'h0;
    seed     = 8'h00;
    tready   = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(pkt_count), 32'd0);
    areset = 1'b0;
    idle_cycles(2);

    // Basic burst, then the same configuration under backpressure and mid-burst noise.
    run_burst(8'h10, 8'd3, 4'd1, 100, 2, 15, 1'b0);
    idle_cycles(2);
    run_burst(8'h10, 8'd3, 4'd1, 50, 2, 15, 1'b1);
    idle_cycles(1);

    // Back-to-back bursts: each new start lands in the previous done cycle.
    for (int i = 0; i < 5; i++) begin
      run_burst(8'($urandom), 8'($urandom_range(15)), 4'($urandom_range(3)),
                $urandom_range(30, 100), 2, 15, 1'b1);
    end
    idle_cycles(1);

    run_burst(8'h00, 8'd255, 4'd0, 100, 2, 15, 1'b0);
    idle_cycles(1);

    // Reset in the middle of a packet.
    seed     = 8'h40;
    pkt_len  = 8'd3;
    num_pkts = 4'd1;
    tready   = 1'b1;
    start    = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge aclk); #1;
    end
    check("pre_rst_tdata", 32'(tdata), 32'h42);
    check("pre_rst_tvalid", 32'(tvalid), 32'd1);
    #2 areset = 1'b1;
    #1;
    check("mid_rst_tvalid", 32'(tvalid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cnt", 32'(pkt_count), 32'd0);
    check("mid_rst_tlast", 32'(tlast), 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    idle_cycles(5);

    // Gapless instance with 2-bit packet counter: wrap and single-beat packets.
    sel = 1'b1;
    run_burst(8'hFE, 8'd0, 4'd3, 100, 0, 3, 1'b0);
    idle_cycles(1);
    for (int i = 0; i < 3; i++) begin
      run_burst(8'($urandom), 8'($urandom_range(7)), 4'($urandom_range(3)), 50, 0, 3, 1'b1);
    end
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
